// File: rtl/cond_eval_unit_pkg.sv
// Shared definitions for the condition evaluation path: condition codes, NZCV bit
// positions and the decoded result payload.
package cond_eval_unit_pkg;

    localparam int unsigned COND_W = 4;
    localparam int unsigned NZCV_W = 4;

    localparam logic [COND_W-1:0] COND_EQ = 4'h0;
    localparam logic [COND_W-1:0] COND_NE = 4'h1;
    localparam logic [COND_W-1:0] COND_CS = 4'h2;
    localparam logic [COND_W-1:0] COND_CC = 4'h3;
    localparam logic [COND_W-1:0] COND_MI = 4'h4;
    localparam logic [COND_W-1:0] COND_PL = 4'h5;
    localparam logic [COND_W-1:0] COND_VS = 4'h6;
    localparam logic [COND_W-1:0] COND_VC = 4'h7;
    localparam logic [COND_W-1:0] COND_HI = 4'h8;
    localparam logic [COND_W-1:0] COND_LS = 4'h9;
    localparam logic [COND_W-1:0] COND_GE = 4'hA;
    localparam logic [COND_W-1:0] COND_LT = 4'hB;
    localparam logic [COND_W-1:0] COND_GT = 4'hC;
    localparam logic [COND_W-1:0] COND_LE = 4'hD;
    localparam logic [COND_W-1:0] COND_AL = 4'hE;
    localparam logic [COND_W-1:0] COND_NV = 4'hF;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic pass;
        logic illegal;
    } cond_res_t;

endpackage

// File: rtl/cond_eval_unit_decode.sv
// Purely combinational condition-code evaluator: (cond, nzcv) -> {pass, illegal}.
// Kept standalone so the issue stage can reuse it without the flag/result registers.
module cond_decode
    import cond_eval_unit_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [NZCV_W-1:0] nzcv,
    output cond_res_t         res_c
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        res_c.pass    = 1'b0;
        res_c.illegal = 1'b0;
        case (cond)
            COND_EQ: res_c.pass = z;
            COND_NE: res_c.pass = !z;
            COND_CS: res_c.pass = c;
            COND_CC: res_c.pass = !c;
            COND_MI: res_c.pass = n;
            COND_PL: res_c.pass = !n;
            COND_VS: res_c.pass = v;
            COND_VC: res_c.pass = !v;
            COND_HI: res_c.pass = c && !z;
            COND_LS: res_c.pass = !c || z;
            COND_GE: res_c.pass = (n == v);
            COND_LT: res_c.pass = (n != v);
            COND_GT: res_c.pass = !z && (n == v);
            COND_LE: res_c.pass = z || (n != v);
            COND_AL: res_c.pass = 1'b1;
            // Reserved encoding never passes and is flagged to the consumer.
            default: res_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_eval_unit.sv
// Architectural NZCV register plus a one-entry registered condition-evaluation stage
// with valid/ready handshake, same-cycle flag bypass and saturating pass/fail counters.
module cond_eval_unit
    import cond_eval_unit_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic [NZCV_W-1:0] flag_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [COND_W-1:0] req_cond,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_pass,
    output logic              resp_illegal,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [NZCV_W-1:0] flags_q,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NZCV_W-1:0] eff_c;
    logic              accept_c;
    cond_res_t         dec_c;

    // A request accepted alongside a flag write must see the new flags.
    assign eff_c     = flag_we ? flag_in : flags_q;
    assign req_ready = !resp_valid || resp_ready;
    assign accept_c  = req_valid && req_ready;

    cond_decode u_decode (
        .cond  (req_cond),
        .nzcv  (eff_c),
        .res_c (dec_c)
    );

    // Architectural flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flag_we) begin
            flags_q <= flag_in;
        end
    end

    // Result register; contents only change on accept so a stalled response stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid   <= 1'b0;
            resp_pass    <= 1'b0;
            resp_illegal <= 1'b0;
            resp_tag     <= '0;
        end else if (accept_c) begin
            resp_valid   <= 1'b1;
            resp_pass    <= dec_c.pass;
            resp_illegal <= dec_c.illegal;
            resp_tag     <= req_tag;
        end else if (resp_ready) begin
            resp_valid   <= 1'b0;
        end
    end

    // Saturating performance counters; illegal conditions count as failures.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (accept_c) begin
            if (dec_c.pass) begin
                if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + CNT_W'(1);
                end
            end else begin
                if (fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cond_eval_unit.sv
// Self-checking bench for cond_eval_unit: directed scenarios plus random traffic against
// a transaction-level reference model; a second instance with 2-bit counters checks saturation.
module tb_cond_eval_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_we;
    logic [3:0] flag_in;
    logic       req_valid;
    logic [3:0] req_cond;
    logic [3:0] req_tag;
    logic       resp_ready;

    logic        req_ready, resp_valid, resp_pass, resp_illegal;
    logic [3:0]  resp_tag, flags_q;
    logic [15:0] pass_cnt, fail_cnt;

    logic       s_req_ready, s_resp_valid, s_resp_pass, s_resp_illegal;
    logic [3:0] s_resp_tag, s_flags_q;
    logic [1:0] s_pass_cnt, s_fail_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic       m_valid, m_pass, m_ill;
    logic [3:0] m_tag, m_flags;
    int         m_pc, m_fc;

    always #5 clk = ~clk;

    cond_eval_unit #(.TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pass(resp_pass),
        .resp_illegal(resp_illegal), .resp_tag(resp_tag), .flags_q(flags_q),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    cond_eval_unit #(.TAG_W(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_cond(req_cond), .req_tag(req_tag),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_pass(s_resp_pass),
        .resp_illegal(s_resp_illegal), .resp_tag(s_resp_tag), .flags_q(s_flags_q),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
    );

    // ARM-style evaluation: cond[3:1] picks a predicate, cond[0] inverts it; 4'hF reserved.
    function automatic logic [1:0] ref_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 2'b01;
        return {base ^ c[0], 1'b0};
    endfunction

    function automatic int sat(input int x, input int max);
        return (x > max) ? max : x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pass = 1'b0; m_ill = 1'b0;
        m_tag = 4'h0; m_flags = 4'h0; m_pc = 0; m_fc = 0;
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic r, input logic fwe, input logic [3:0] fin, input logic rv,
                        input logic [3:0] c, input logic [3:0] t, input logic rr);
        logic [3:0] eff;
        logic [1:0] res;
        logic       rdy;
        @(negedge clk);
        rst = r; flag_we = fwe; flag_in = fin; req_valid = rv;
        req_cond = c; req_tag = t; resp_ready = rr;
        #1;
        rdy = !m_valid || rr;
        if (!r) check("req_ready", 32'(req_ready), 32'(rdy));
        check("resp_valid", 32'(resp_valid), 32'(m_valid));
        check("resp_pass", 32'(resp_pass), 32'(m_pass));
        check("resp_illegal", 32'(resp_illegal), 32'(m_ill));
        check("resp_tag", 32'(resp_tag), 32'(m_tag));
        check("flags_q", 32'(flags_q), 32'(m_flags));
        check("pass_cnt", 32'(pass_cnt), 32'(sat(m_pc, 65535)));
        check("fail_cnt", 32'(fail_cnt), 32'(sat(m_fc, 65535)));
        check("s_pass_cnt", 32'(s_pass_cnt), 32'(sat(m_pc, 3)));
        check("s_fail_cnt", 32'(s_fail_cnt), 32'(sat(m_fc, 3)));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            eff = fwe ? fin : m_flags;
            if (fwe) m_flags = fin;
            if (rv && rdy) begin
                res = ref_eval(c, eff);
                m_valid = 1'b1; m_pass = res[1]; m_ill = res[0]; m_tag = t;
                if (res[1]) m_pc++; else m_fc++;
            end else if (rr) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flag_we = 1'b0; flag_in = 4'h0; req_valid = 1'b0;
        req_cond = 4'h0; req_tag = 4'h0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // 1: reset state, EQ with Z=0 fails
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h3, 1'b1);
        #1;
        check("t1_valid", 32'(resp_valid), 32'd1);
        check("t1_pass", 32'(resp_pass), 32'd0);
        check("t1_tag", 32'(resp_tag), 32'd3);

        // 2: bypass of a same-cycle flag write
        step(1'b0, 1'b1, 4'b0100, 1'b1, 4'h0, 4'h5, 1'b1);
        #1;
        check("t2_pass", 32'(resp_pass), 32'd1);
        check("t2_flags", 32'(flags_q), 32'b0100);

        // Reserved condition
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 4'h2, 1'b1);
        #1;
        check("t_nv_pass", 32'(resp_pass), 32'd0);
        check("t_nv_illegal", 32'(resp_illegal), 32'd1);

        // 3: every condition against every flag value
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 16; c++)
                step(1'b0, 1'b1, 4'(f), 1'b1, 4'(c), 4'($urandom), 1'b1);
        idle();

        // 4: stall with a pending request and toggling flag writes, then release
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'h2, 4'h1, 1'b1);
        for (int k = 0; k < 3; k++)
            step(1'b0, (k % 2) == 0, 4'($urandom), 1'b1, 4'h8, 4'h9, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'h8, 4'h9, 1'b1);
        idle();

        // 5: eight back-to-back requests after a reset
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 8; k++)
            step(1'b0, 1'b0, 4'h0, 1'b1, 4'($urandom), 4'(k), 1'b1);
        idle();
        check("t5_sum", 32'(pass_cnt) + 32'(fail_cnt), 32'd8);

        // 6: saturation of 2-bit counters, then reset with a response outstanding
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 4'h0, 1'b1, 4'hE, 4'(k), 1'b1);
        #1;
        check("t6_sat", 32'(s_pass_cnt), 32'd3);
        check("t6_big", 32'(pass_cnt), 32'd5);
        step(1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 4'h7, 1'b0);
        #1;
        check("t6_rst_valid", 32'(resp_valid), 32'd0);
        check("t6_rst_flags", 32'(flags_q), 32'd0);
        check("t6_rst_cnt", 32'(s_pass_cnt), 32'd0);

        // Random traffic with back-pressure and occasional resets
        for (int k = 0; k < 400; k++)
            step(($urandom % 32) == 0, $urandom % 2, 4'($urandom), $urandom % 4 != 0,
                 4'($urandom), 4'($urandom), $urandom % 3 != 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
